broadcast_queue: RTL
====================

BROADCAST_QUEUE -- requirements
Module: broadcast_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, result width.
REQ-002 SHALL have parameter TAG_WIDTH, default 7, execution tag width.
REQ-003 SHALL have parameter NUM_PORTS, default 4, number of FU input ports.
REQ-004 SHALL have parameter DEPTH, default 8, entries; power of two, >= NUM_PORTS.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 fu_done  input  NUM_PORTS  per-port one-cycle completion pulse from FU.
REQ-008 fu_result  input  NUM_PORTS*DATA_WIDTH  per-port result; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 fu_tag  input  NUM_PORTS*TAG_WIDTH  per-port execution tag, same packing.
REQ-010 fu_queued  output  NUM_PORTS  combinational; bit i high in the cycle port i's done is accepted.
REQ-011 cdb_valid  output  1  head entry available for broadcast.
REQ-012 cdb_data  output  DATA_WIDTH  head entry result.
REQ-013 cdb_tag  output  TAG_WIDTH  head entry tag.
REQ-014 cdb_ready  input  1  bus consumer takes head this cycle when cdb_valid.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 overflow  output  1  sticky drop flag (see Configuration).

Function
REQ-017 SHALL be a circular FIFO; cdb_valid = (count != 0); cdb_data/cdb_tag driven from head entry (show-ahead), undefined-but-stable content irrelevant when cdb_valid low.
REQ-018 Pop SHALL occur when cdb_valid & cdb_ready; head pointer advances by 1, wrapping modulo DEPTH.
REQ-019 Free slots this cycle SHALL = DEPTH - count + (pop ? 1 : 0).
REQ-020 Multiple fu_done bits SHALL be accepted in one cycle; acceptance in ascending port index until free slots exhausted; remaining done bits get fu_queued low.
REQ-021 fu_queued[i] SHALL never be high when fu_done[i] is low.
REQ-022 Accepted entries SHALL be written in ascending port order at consecutive tail positions (wrap modulo DEPTH); entry visible on cdb_* no earlier than next cycle.
REQ-023 count SHALL update as count + accepted - pop each cycle; never exceeds DEPTH, never underflows.
REQ-024 Full queue with simultaneous pop SHALL accept exactly one port (lowest index asserting done).
REQ-025 Empty queue SHALL not pop regardless of cdb_ready; no bypass of input to cdb_* in same cycle.
REQ-026 Broadcast order SHALL be strict FIFO across cycles; within a cycle, lower port first.

Reset
REQ-027 While rst high: head, tail, count <= 0; cdb_valid low; fu_queued all low (combinationally gated); overflow <= 0.
REQ-028 Reset mid-operation SHALL discard all stored entries; first cycle after rst low behaves as empty queue.

Configuration
REQ-029 Macro BQ_OVERFLOW_FLAG_EN: when defined, overflow SHALL set (registered, sticky until rst) in any cycle where some fu_done bit is high with its fu_queued low; when undefined, overflow SHALL be constant 0 and no flag register exists.

Verification
REQ-030 Reset, then fu_done=0001, tag 0x05, result 0xDEADBEEF -> fu_queued=0001 same cycle; next cycle cdb_valid=1, cdb_tag=0x05, cdb_data=0xDEADBEEF, count=1.
REQ-031 Empty, cdb_ready=0, fu_done=1111 tags 1,2,3,4 -> fu_queued=1111, count=4; then cdb_ready=1 -> broadcasts tags 1,2,3,4 on four consecutive cycles, then cdb_valid=0.
REQ-032 count=6, cdb_ready=0, fu_done=1111 -> fu_queued=0011, count=8; with BQ_OVERFLOW_FLAG_EN overflow=1 next cycle and stays 1; without, overflow=0.
REQ-033 count=8, cdb_valid=1, cdb_ready=1, fu_done=0110 -> fu_queued=0010, count stays 8, head advances by one.
REQ-034 Fill 8, drain 5, enqueue 4 (tail wraps) -> broadcast order preserved, count=7 after enqueue.
REQ-035 rst asserted with count=5 and fu_done=0001 -> fu_queued=0000, next cycle count=0, cdb_valid=0, overflow=0.

Source files
------------

// File: rtl/broadcast_queue_if.sv
// Bus bundle between the functional units / result-bus consumer and the
// broadcast queue. The master modport is the environment side (FUs plus
// bus consumer); the slave modport is the queue itself.
interface broadcast_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int NUM_PORTS  = 4,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_PORTS-1:0]            fu_done;
    logic [NUM_PORTS*DATA_WIDTH-1:0] fu_result;
    logic [NUM_PORTS*TAG_WIDTH-1:0]  fu_tag;
    logic [NUM_PORTS-1:0]            fu_queued;
    logic                            cdb_valid;
    logic [DATA_WIDTH-1:0]           cdb_data;
    logic [TAG_WIDTH-1:0]            cdb_tag;
    logic                            cdb_ready;
    logic [CNT_W-1:0]                count;
    logic                            overflow;

    modport master (
        output fu_done, fu_result, fu_tag, cdb_ready,
        input  fu_queued, cdb_valid, cdb_data, cdb_tag, count, overflow
    );

    modport slave (
        input  fu_done, fu_result, fu_tag, cdb_ready,
        output fu_queued, cdb_valid, cdb_data, cdb_tag, count, overflow
    );
endinterface

// File: rtl/broadcast_queue.sv
// Broadcast queue: collects completion results from NUM_PORTS functional
// units into a circular FIFO and presents the oldest entry on the common
// data bus (show-ahead). Several ports may enqueue in one cycle; they are
// accepted in ascending port order while free slots remain.
// Optional feature macro: BQ_OVERFLOW_FLAG_EN -- when defined, a sticky
// overflow register records any cycle in which a done pulse was dropped;
// otherwise overflow is tied to 0.
module broadcast_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int NUM_PORTS  = 4,
    parameter int DEPTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    broadcast_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [TAG_WIDTH-1:0]  r_tag  [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  w_valid;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_free;
    logic [CNT_W-1:0]      w_acc;
    logic [NUM_PORTS-1:0]  w_queued;
    logic [PTR_W-1:0]      w_wr_idx [NUM_PORTS];

    // Head availability and pop; everything is held off while reset is high.
    assign w_valid = (r_count != '0) && !rst;
    assign w_pop   = w_valid && bus.cdb_ready;
    assign w_free  = DEPTH_C - r_count + {{(CNT_W-1){1'b0}}, w_pop};

    // Accept done pulses lowest port first until the free slots run out.
    always_comb begin
        // NOTE: every output of this block gets a default before the loop so no latch is inferred.
        w_queued = '0;
        w_acc    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_wr_idx[i] = r_tail + w_acc[PTR_W-1:0];
            if (bus.fu_done[i] && !rst && (w_acc < w_free)) begin
                w_queued[i] = 1'b1;
                w_acc       = w_acc + 1'b1;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + {{(PTR_W-1){1'b0}}, w_pop};
            r_tail  <= r_tail + w_acc[PTR_W-1:0];
            r_count <= r_count + w_acc - {{(CNT_W-1){1'b0}}, w_pop};
        end
    end

    // Storage writes for accepted ports at consecutive tail slots.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; count gates its visibility.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_queued[i]) begin
                r_data[w_wr_idx[i]] <= bus.fu_result[i*DATA_WIDTH +: DATA_WIDTH];
                r_tag[w_wr_idx[i]]  <= bus.fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

`ifdef BQ_OVERFLOW_FLAG_EN
    logic r_overflow;

    // Sticky record of any done pulse that was not accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (|(bus.fu_done & ~w_queued)) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow = r_overflow;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.fu_queued = w_queued;
    assign bus.cdb_valid = w_valid;
    assign bus.cdb_data  = r_data[r_head];
    assign bus.cdb_tag   = r_tag[r_head];
    assign bus.count     = r_count;
endmodule
